// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types and constants for the PC/next-PC stage
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } redirect_sel_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - redirect target arithmetic, priority select and alignment check
module next_pc_sel
  import pc_fetch_pkg::*;
(
  input  logic [31:0] br_pc4_i,
  input  logic        branch_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic        misaligned_o
);

  redirect_sel_t sel;
  logic [31:0]   br_target;
  logic [31:0]   j_target;

  assign br_target = br_pc4_i + br_offset_i;
  assign j_target  = {br_pc4_i[31:28], jump_index_i, 2'b00};

  // jr outranks jump, jump outranks a taken branch; an untaken branch is sequential
  always_comb begin
    sel = SEL_SEQ;
    if (jr_i)                     sel = SEL_JR;
    else if (jump_i)              sel = SEL_J;
    else if (branch_i && br_taken_i) sel = SEL_BR;
  end

  always_comb begin
    target_o = 32'd0;
    case (sel)
      SEL_BR:  target_o = br_target;
      SEL_J:   target_o = j_target;
      SEL_JR:  target_o = jr_addr_i;
      default: target_o = 32'd0;
    endcase
  end

  assign redirect_o   = (sel != SEL_SEQ);
  assign misaligned_o = redirect_o && (target_o[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, fetch handshake, redirect flush and misalignment trap
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic [31:0] br_pc4_i,
  input  logic        branch_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  output logic        flush_o,
  output logic        trap_o,
  output logic [31:0] trap_addr_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  fetch_state_t state, state_next;
  logic [31:0]  pc_q, pc_next;
  logic [31:0]  trap_addr_q, trap_addr_next;
  logic [31:0]  count_q, count_next;
  logic [2:0]   flush_cnt_q, flush_cnt_next;
  logic         started_q;
  logic         redirect;
  logic [31:0]  target;
  logic         misaligned;
  logic         active;

  next_pc_sel u_next_pc_sel (
    .br_pc4_i     (br_pc4_i),
    .branch_i     (branch_i),
    .br_taken_i   (br_taken_i),
    .br_offset_i  (br_offset_i),
    .jump_i       (jump_i),
    .jump_index_i (jump_index_i),
    .jr_i         (jr_i),
    .jr_addr_i    (jr_addr_i),
    .redirect_o   (redirect),
    .target_o     (target),
    .misaligned_o (misaligned)
  );

  // started_q keeps fetch_valid_o low for the first cycle after reset release
  assign active = (state == ST_RUN) && started_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_RUN;
      pc_q        <= RESET_PC;
      trap_addr_q <= 32'd0;
      count_q     <= 32'd0;
      flush_cnt_q <= 3'd0;
      started_q   <= 1'b0;
    end else begin
      state       <= state_next;
      pc_q        <= pc_next;
      trap_addr_q <= trap_addr_next;
      count_q     <= count_next;
      flush_cnt_q <= flush_cnt_next;
      started_q   <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc_q;
    trap_addr_next = trap_addr_q;
    count_next     = count_q;
    flush_cnt_next = flush_cnt_q;
    case (state)
      ST_RUN: begin
        if (active && !stall_i) begin
          if (redirect && !misaligned) begin
            pc_next        = target;
            state_next     = ST_FLUSH;
            flush_cnt_next = FLUSH_INIT;
          end else if (redirect) begin
            trap_addr_next = target;
            state_next     = ST_TRAP;
          end else if (fetch_ready_i) begin
            pc_next    = pc_q + PC_STEP;
            count_next = count_q + 32'd1;
          end
        end
      end
      ST_FLUSH: begin
        flush_cnt_next = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) state_next = ST_RUN;
      end
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_RUN;
    endcase
  end

  assign fetch_valid_o = active;
  assign flush_o       = (state == ST_FLUSH);
  assign trap_o        = (state == ST_TRAP);
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + PC_STEP;
  assign trap_addr_o   = trap_addr_q;
  assign fetch_count_o = count_q;

endmodule
